// File: rtl/crc16_check.sv
// Serial CRC-16 checker: recomputes the payload CRC bit by bit and compares it with the 16 trailing CRC bits.
// Latency: done pulses 1 cycle after the 16th CRC bit is accepted (LEN+17 cycles after START with no gaps).
// Backpressure: none; IN_VALID=0 simply freezes all block state, and START aborts and restarts at any time.
module crc16_check #(
    parameter logic [15:0] SEED  = 16'h0000,
    parameter int          LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             DATA,
    input  logic             IN_VALID,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [15:0]      remainder,
    output logic [15:0]      rx_crc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRCIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter reload for the CRC phase; the counter is LEN_W bits wide, so
    // LEN_W must be at least 5 to hold this value.
    localparam logic [LEN_W-1:0] CRC_BITS = LEN_W'(16);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [LEN_W-1:0] cnt_q;
    logic [15:0]      rem_q;
    logic [15:0]      rx_q;
    logic             busy_q;
    logic             done_q;
    logic             ok_q;
    logic             err_q;
    logic             fb;
    logic             cnt_last;

    // LFSR next state for one accepted payload bit: feedback is DATA xor L[0],
    // injected at taps 0, 5 and 12 while the register shifts towards the MSB.
    always_comb begin
        fb         = DATA ^ lfsr_q[0];
        lfsr_d     = {lfsr_q[14:0], fb};
        lfsr_d[5]  = lfsr_q[4] ^ fb;
        lfsr_d[12] = lfsr_q[11] ^ fb;
    end

    // The counter counts down to 1 rather than 0 so that LEN = 2^LEN_W-1
    // never needs a wider register.
    assign cnt_last = (cnt_q == ONE);

    // Block FSM with all outputs registered; START overrides every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            rem_q   <= 16'h0000;
            rx_q    <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (START) begin
                // Restart from scratch; any bit presented alongside START is dropped.
                lfsr_q <= SEED;
                rx_q   <= 16'h0000;
                ok_q   <= 1'b0;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
                if (LEN == '0) begin
                    // Empty payload: the remainder is just the preload value.
                    rem_q   <= SEED;
                    cnt_q   <= CRC_BITS;
                    state_q <= CRCIN;
                end else begin
                    cnt_q   <= LEN;
                    state_q <= PAYLOAD;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    PAYLOAD: begin
                        if (IN_VALID) begin
                            lfsr_q <= lfsr_d;
                            if (cnt_last) begin
                                rem_q   <= lfsr_d;
                                cnt_q   <= CRC_BITS;
                                state_q <= CRCIN;
                            end else begin
                                cnt_q <= cnt_q - ONE;
                            end
                        end
                    end
                    CRCIN: begin
                        // First received CRC bit ends up in rx_crc[15].
                        if (IN_VALID) begin
                            rx_q <= {rx_q[14:0], DATA};
                            if (cnt_last) begin
                                state_q <= DONE;
                            end else begin
                                cnt_q <= cnt_q - ONE;
                            end
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ok_q    <= (rx_q == rem_q);
                        err_q   <= (rx_q != rem_q);
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign remainder = rem_q;
    assign rx_crc    = rx_q;

endmodule

// File: tb/tb_crc16_check.sv
// Self-checking bench for crc16_check: spec vectors, abort/reset sequences and random blocks vs a CRC model.
// Two instances (SEED 0 and SEED FFFF) share stimulus; sel picks whose outputs are compared.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled at the same point.
module tb_crc16_check;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] LEN = 16'd0;
    logic        DATA = 1'b0;
    logic        IN_VALID = 1'b0;

    logic        busy_a, done_a, ok_a, err_a;
    logic [15:0] rem_a, rx_a;
    logic        busy_b, done_b, ok_b, err_b;
    logic [15:0] rem_b, rx_b;

    logic        sel = 1'b0;
    logic        busy_s, done_s, ok_s, err_s;
    logic [15:0] rem_s, rx_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    bit stream_q[$];

    crc16_check #(.SEED(16'h0000), .LEN_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .DATA(DATA), .IN_VALID(IN_VALID),
        .busy(busy_a), .done(done_a), .crc_ok(ok_a), .crc_err(err_a),
        .remainder(rem_a), .rx_crc(rx_a)
    );

    crc16_check #(.SEED(16'hFFFF), .LEN_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .DATA(DATA), .IN_VALID(IN_VALID),
        .busy(busy_b), .done(done_b), .crc_ok(ok_b), .crc_err(err_b),
        .remainder(rem_b), .rx_crc(rx_b)
    );

    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign ok_s   = sel ? ok_b   : ok_a;
    assign err_s  = sel ? err_b  : err_a;
    assign rem_s  = sel ? rem_b  : rem_a;
    assign rx_s   = sel ? rx_b   : rx_a;

    always #5 CLK = ~CLK;

    // Count done pulses and flag back-to-back done or simultaneous ok/err.
    always @(negedge CLK) begin
        if (done_a) dcnt_a++;
        if (done_b) dcnt_b++;
        if (done_a && prev_a) begin
            errors++;
            $display("FAIL done_consecutive_a actual=1 required=0");
        end
        if (done_b && prev_b) begin
            errors++;
            $display("FAIL done_consecutive_b actual=1 required=0");
        end
        if ((ok_a && err_a) || (ok_b && err_b)) begin
            errors++;
            $display("FAIL ok_err_both actual=1 required=0");
        end
        prev_a = done_a;
        prev_b = done_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference CRC: polynomial-division form over the first n bits of stream_q.
    function automatic logic [15:0] model(input logic [15:0] seed, input int n);
        logic [15:0] r;
        bit f;
        r = seed;
        for (int i = 0; i < n; i++) begin
            f = stream_q[i] ^ r[0];
            r = {r[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    function automatic int dcnt_sel();
        return sel ? dcnt_b : dcnt_a;
    endfunction

    task automatic push_crc(input logic [15:0] c);
        for (int k = 15; k >= 0; k--) stream_q.push_back(c[k]);
    endtask

    task automatic start_blk(input int len);
        START = 1'b1;
        LEN = len[15:0];
        IN_VALID = 1'b1;  // presented with START: must be discarded
        DATA = 1'b1;
        tick();
        START = 1'b0;
        IN_VALID = 1'b0;
        cyc = 0;
        chk("busy_after_start", {31'd0, busy_s}, 32'd1);
    endtask

    task automatic send_stream(input int gap, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            if (i > from) begin
                repeat (gap) begin
                    IN_VALID = 1'b0;
                    tick();
                    cyc++;
                end
            end
            IN_VALID = 1'b1;
            DATA = stream_q[i];
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        DATA = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (done_s !== 1'b1 && n < 64) begin
            tick();
            cyc++;
            n++;
        end
        lat = (done_s === 1'b1) ? cyc : -1;
    endtask

    typedef struct {
        bit          s;
        int          len;
        logic [15:0] pay;   // pay[0] is sent first
        logic [15:0] crc;   // sent MSB first
        int          gap;
        logic [15:0] rem;
        logic [15:0] rx;
        bit          ok;
        int          lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        int lat, d0, len, gap, idx, nb;
        logic [15:0] c, er, erx;
        bit corrupt;

        vt[0] = '{1'b0, 1, 16'h0001, 16'h1021, 0, 16'h1021, 16'h1021, 1'b1, 18};
        vt[1] = '{1'b0, 2, 16'h0003, 16'h2042, 0, 16'h2042, 16'h2042, 1'b1, 19};
        vt[2] = '{1'b0, 2, 16'h0003, 16'h2842, 0, 16'h2042, 16'h2842, 1'b0, 19};
        vt[3] = '{1'b1, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 16'hFFFF, 1'b1, 17};
        vt[4] = '{1'b1, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 1'b0, 17};
        vt[5] = '{1'b0, 2, 16'h0003, 16'h2042, 3, 16'h2042, 16'h2042, 1'b1, 70};

        // Reset state
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ok", {31'd0, ok_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_rem", {16'd0, rem_a}, 32'd0);
        chk("rst_rx", {16'd0, rx_a}, 32'd0);
        chk("rst_rem_b", {16'd0, rem_b}, 32'd0);

        // Specification vectors
        for (int v = 0; v < 6; v++) begin
            sel = vt[v].s;
            stream_q.delete();
            for (int j = 0; j < vt[v].len; j++) stream_q.push_back(vt[v].pay[j]);
            push_crc(vt[v].crc);
            d0 = dcnt_sel();
            start_blk(vt[v].len);
            send_stream(vt[v].gap, 0, stream_q.size());
            wait_done(lat);
            chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
            chk($sformatf("v%0d_busy_at_done", v), {31'd0, busy_s}, 32'd0);
            chk($sformatf("v%0d_rem", v), {16'd0, rem_s}, {16'd0, vt[v].rem});
            chk($sformatf("v%0d_rx", v), {16'd0, rx_s}, {16'd0, vt[v].rx});
            chk($sformatf("v%0d_ok", v), {31'd0, ok_s}, {31'd0, vt[v].ok});
            chk($sformatf("v%0d_err", v), {31'd0, err_s}, {31'd0, ~vt[v].ok});
            repeat (3) tick();
            chk($sformatf("v%0d_ok_hold", v), {31'd0, ok_s}, {31'd0, vt[v].ok});
            chk($sformatf("v%0d_done_count", v), dcnt_sel() - d0, 32'd1);
        end

        // Abort mid-CRCIN, then a fresh LEN=1 block
        sel = 1'b0;
        stream_q.delete();
        stream_q.push_back(1'b1);
        push_crc(16'h1021);
        d0 = dcnt_a;
        start_blk(1);
        send_stream(0, 0, 6);
        start_blk(1);
        chk("abort_ok_cleared", {31'd0, ok_a}, 32'd0);
        send_stream(0, 0, 17);
        wait_done(lat);
        chk("abort_latency", lat, 32'd18);
        chk("abort_ok", {31'd0, ok_a}, 32'd1);
        repeat (3) tick();
        chk("abort_done_count", dcnt_a - d0, 32'd1);

        // Reset mid-PAYLOAD
        stream_q.delete();
        for (int j = 0; j < 8; j++) stream_q.push_back(bit'($urandom_range(0, 1)));
        start_blk(8);
        send_stream(0, 0, 4);
        d0 = dcnt_a;
        RST = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_done", {31'd0, done_a}, 32'd0);
        chk("midrst_ok", {31'd0, ok_a}, 32'd0);
        chk("midrst_err", {31'd0, err_a}, 32'd0);
        chk("midrst_rem", {16'd0, rem_a}, 32'd0);
        chk("midrst_rx", {16'd0, rx_a}, 32'd0);
        tick();
        RST = 1'b0;
        IN_VALID = 1'b1;
        repeat (20) tick();
        IN_VALID = 1'b0;
        chk("midrst_no_done", dcnt_a - d0, 32'd0);
        chk("midrst_idle_busy", {31'd0, busy_a}, 32'd0);

        // Random blocks, alternating correct / single-bit-corrupted
        for (int it = 0; it < 20; it++) begin
            sel = (it % 4) >= 2;
            len = $urandom_range(1, 1024);
            gap = $urandom_range(0, 1);
            corrupt = (it % 2) == 1;
            stream_q.delete();
            for (int j = 0; j < len; j++) stream_q.push_back(bit'($urandom_range(0, 1)));
            c = model(sel ? 16'hFFFF : 16'h0000, len);
            push_crc(c);
            if (corrupt) begin
                idx = $urandom_range(0, len + 15);
                stream_q[idx] = ~stream_q[idx];
            end
            er = model(sel ? 16'hFFFF : 16'h0000, len);
            for (int k = 0; k < 16; k++) erx[15 - k] = stream_q[len + k];
            nb = len + 16;
            d0 = dcnt_sel();
            start_blk(len);
            send_stream(gap, 0, nb);
            wait_done(lat);
            chk($sformatf("rnd%0d_latency", it), lat, len + 17 + gap * (nb - 1));
            chk($sformatf("rnd%0d_rem", it), {16'd0, rem_s}, {16'd0, er});
            chk($sformatf("rnd%0d_rx", it), {16'd0, rx_s}, {16'd0, erx});
            chk($sformatf("rnd%0d_ok", it), {31'd0, ok_s}, {31'd0, ~corrupt});
            chk($sformatf("rnd%0d_err", it), {31'd0, err_s}, {31'd0, corrupt});
            tick();
            chk($sformatf("rnd%0d_done_count", it), dcnt_sel() - d0, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
